// File: rtl/n_bit_counter_pkg.sv
// Shared types and constants for the n-bit down counter family.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package n_bit_counter_pkg;

   // Default counter width in bits.
   localparam int DEFAULT_N = 8;

   // Controller states: waiting for a load, counting down, finished (one-shot only).
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

endpackage : n_bit_counter_pkg

// File: rtl/n_bit_down_counter.sv
// Loadable down counter with terminal-count pulse, busy flag and optional periodic reload.
// Latency: a load sampled at edge k shows count==load_value and busy after edge k; zero is combinational.
// Backpressure: none; enable=0 simply freezes a running count, load always wins over enable.
module n_bit_down_counter
   import n_bit_counter_pkg::*;
#(
   parameter int N           = DEFAULT_N,
   parameter bit AUTO_RELOAD = 1'b0
) (
   input  logic         clock,
   input  logic         clear,
   input  logic         load,
   input  logic [0:N-1] load_value,
   input  logic         enable,
   output logic [0:N-1] count,
   output logic         zero,
   output logic         tc,
   output logic         busy
);

   state_t       state_q;
   logic [0:N-1] count_q;
   logic [0:N-1] reload_q;
   logic         tc_q;
   logic         busy_q;

   // Bit 0 is the MSB throughout, so plain arithmetic on the vectors is numerically correct.
   // Single register block: clear dominates, then load, then counting in RUN.
   always_ff @(posedge clock) begin
      if (!clear) begin
         state_q  <= IDLE;
         count_q  <= '0;
         reload_q <= '0;
         tc_q     <= 1'b0;
         busy_q   <= 1'b0;
      end else if (load) begin
         // Restart from any state; a zero load is already at terminal count.
         count_q  <= load_value;
         reload_q <= load_value;
         if (load_value == '0) begin
            tc_q <= 1'b1;
            if (AUTO_RELOAD) begin
               state_q <= RUN;
               busy_q  <= 1'b1;
            end else begin
               state_q <= DONE;
               busy_q  <= 1'b0;
            end
         end else begin
            tc_q    <= 1'b0;
            state_q <= RUN;
            busy_q  <= 1'b1;
         end
      end else begin
         tc_q <= 1'b0;
         case (state_q)
            RUN: begin
               if (enable) begin
                  if (count_q > N'(1)) begin
                     count_q <= count_q - N'(1);
                  end else if (count_q == N'(1)) begin
                     count_q <= '0;
                     tc_q    <= 1'b1;
                     if (!AUTO_RELOAD) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                     end
                  end else if (AUTO_RELOAD) begin
                     // Sitting at zero: start the next period; a zero period pulses tc every cycle.
                     count_q <= reload_q;
                     tc_q    <= (reload_q == '0);
                  end else begin
                     // Unreachable in one-shot mode, but never let zero wrap.
                     state_q <= DONE;
                     busy_q  <= 1'b0;
                  end
               end
            end
            IDLE, DONE: begin
               busy_q <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign count = count_q;
   assign zero  = (count_q == '0);
   assign tc    = tc_q;
   assign busy  = busy_q;

endmodule : n_bit_down_counter

// File: tb/tb_n_bit_down_counter.sv
// Scoreboard bench for n_bit_down_counter: one one-shot and one auto-reload instance share stimulus.
// Latency: expected values are due one clock after the inputs are applied.
// Backpressure: n/a.
module tb_n_bit_down_counter;

   logic       clk = 1'b0;
   logic       clear = 1'b0;
   logic       load = 1'b0;
   logic [0:7] load_value = '0;
   logic       enable = 1'b0;

   logic [0:7] count0, count1;
   logic       zero0, zero1, tc0, tc1, busy0, busy1;

   typedef struct {
      int         due;
      bit         sel;
      logic [7:0] cnt;
      bit         tcv;
      bit         bsy;
      string      name;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;

   logic [7:0] ac;
   logic       at, ab, az;

   n_bit_down_counter #(.N(8), .AUTO_RELOAD(1'b0)) dut0 (
      .clock(clk), .clear(clear), .load(load), .load_value(load_value), .enable(enable),
      .count(count0), .zero(zero0), .tc(tc0), .busy(busy0)
   );

   n_bit_down_counter #(.N(8), .AUTO_RELOAD(1'b1)) dut1 (
      .clock(clk), .clear(clear), .load(load), .load_value(load_value), .enable(enable),
      .count(count1), .zero(zero1), .tc(tc1), .busy(busy1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compare every entry whose due cycle has just been clocked.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].due == cyc) begin
         e = sb.pop_front();
         if (e.sel) begin
            ac = count1; at = tc1; ab = busy1; az = zero1;
         end else begin
            ac = count0; at = tc0; ab = busy0; az = zero0;
         end
         vectors++;
         if (ac !== e.cnt || at !== e.tcv || ab !== e.bsy || az !== (e.cnt == 8'd0)) begin
            miscompares++;
            $display("FAIL %s (dut%0d): got count=%0d tc=%b busy=%b zero=%b, want count=%0d tc=%b busy=%b zero=%b",
                     e.name, e.sel, ac, at, ab, az, e.cnt, e.tcv, e.bsy, (e.cnt == 8'd0));
         end
      end
   end

   // Push an expectation for the edge that follows the most recent drive.
   task automatic expect_out(input bit sel, input int cnt, input bit tcv, input bit bsy, input string name);
      exp_t x;
      x.due = cyc + 1; x.sel = sel; x.cnt = cnt[7:0]; x.tcv = tcv; x.bsy = bsy; x.name = name;
      sb.push_back(x);
   endtask

   // Drive one cycle of inputs and record the expected registered response.
   task automatic step(input bit clr_n, input bit ld, input int lv, input bit en,
                       input bit sel, input int cnt, input bit tcv, input bit bsy, input string name);
      @(negedge clk);
      clear = clr_n; load = ld; load_value = lv[7:0]; enable = en;
      expect_out(sel, cnt, tcv, bsy, name);
   endtask

   initial begin
      // Clear held two cycles while load/enable are asserted.
      step(0, 1, 55, 1, 0, 0, 0, 0, "reset0_a");
      expect_out(1, 0, 0, 0, "reset1_a");
      step(0, 1, 55, 1, 0, 0, 0, 0, "reset0_b");
      expect_out(1, 0, 0, 0, "reset1_b");

      // One-shot: load 5, continuous enable.
      step(1, 1, 5, 1, 0, 5, 0, 1, "os_load5");
      for (int i = 4; i >= 1; i--) step(1, 0, 0, 1, 0, i, 0, 1, "os_dec");
      step(1, 0, 0, 1, 0, 0, 1, 0, "os_tc");
      step(1, 0, 0, 1, 0, 0, 0, 0, "os_hold_a");
      step(1, 0, 0, 1, 0, 0, 0, 0, "os_hold_b");

      // Enable gaps: load 3, enable 1,0,0,1,1.
      step(1, 1, 3, 0, 0, 3, 0, 1, "gap_load3");
      step(1, 0, 0, 1, 0, 2, 0, 1, "gap_e1");
      step(1, 0, 0, 0, 0, 2, 0, 1, "gap_e0a");
      step(1, 0, 0, 0, 0, 2, 0, 1, "gap_e0b");
      step(1, 0, 0, 1, 0, 1, 0, 1, "gap_e1b");
      step(1, 0, 0, 1, 0, 0, 1, 0, "gap_tc");
      step(1, 0, 0, 1, 0, 0, 0, 0, "gap_after");

      // Mid-run reload at 190.
      step(1, 1, 200, 1, 0, 200, 0, 1, "mr_load200");
      for (int i = 1; i <= 10; i++) step(1, 0, 0, 1, 0, 200 - i, 0, 1, "mr_dec");
      step(1, 1, 7, 1, 0, 7, 0, 1, "mr_reload7");
      step(1, 0, 0, 1, 0, 6, 0, 1, "mr_dec7");

      // Mid-run clear at 190 with load asserted, then one-shot load of zero.
      step(1, 1, 200, 1, 0, 200, 0, 1, "mc_load200");
      for (int i = 1; i <= 10; i++) step(1, 0, 0, 1, 0, 200 - i, 0, 1, "mc_dec");
      step(0, 1, 9, 1, 0, 0, 0, 0, "mc_clear");
      step(1, 1, 0, 1, 0, 0, 1, 0, "mc_load0");
      step(1, 0, 0, 1, 0, 0, 0, 0, "mc_done");
      step(1, 1, 2, 0, 0, 2, 0, 1, "done_reload");
      step(1, 0, 0, 0, 0, 2, 0, 1, "run_hold");

      // Auto-reload instance from a clean state.
      step(0, 0, 0, 0, 1, 0, 0, 0, "ar_clear");
      step(1, 1, 2, 1, 1, 2, 0, 1, "ar_load2");
      step(1, 0, 0, 1, 1, 1, 0, 1, "ar_1a");
      step(1, 0, 0, 1, 1, 0, 1, 1, "ar_0a");
      step(1, 0, 0, 1, 1, 2, 0, 1, "ar_2b");
      step(1, 0, 0, 1, 1, 1, 0, 1, "ar_1b");
      step(1, 0, 0, 1, 1, 0, 1, 1, "ar_0b");
      step(1, 0, 0, 0, 1, 0, 0, 1, "ar_hold0");
      step(1, 0, 0, 1, 1, 2, 0, 1, "ar_2c");

      // Auto-reload of zero: tc every enabled cycle.
      step(1, 1, 0, 1, 1, 0, 1, 1, "arz_load0");
      step(1, 0, 0, 1, 1, 0, 1, 1, "arz_e1a");
      step(1, 0, 0, 1, 1, 0, 1, 1, "arz_e1b");
      step(1, 0, 0, 0, 1, 0, 0, 1, "arz_e0");
      step(1, 0, 0, 1, 1, 0, 1, 1, "arz_e1c");

      @(negedge clk);
      load = 1'b0; enable = 1'b0;
      repeat (3) @(negedge clk);
      if (sb.size() != 0) begin
         $display("FAIL drain: got %0d unchecked expectations, want 0", sb.size());
         miscompares += sb.size();
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_n_bit_down_counter

// File: doc/n_bit_down_counter.md
N_BIT_DOWN_COUNTER -- requirements
Module: n_bit_down_counter

Interface
REQ-001 Parameter N, default 8, counter width in bits (N >= 2).
REQ-002 Parameter AUTO_RELOAD, default 0, 1 = periodic reload at terminal count, 0 = one-shot.
REQ-003 clock  input  1  single clock; all state changes on rising edge.
REQ-004 clear  input  1  synchronous, active-low reset, sampled on rising edge of clock.
REQ-005 load  input  1  request to load load_value and start counting.
REQ-006 load_value  input  N  start value; bit 0 is MSB, matching count ordering.
REQ-007 enable  input  1  count-down qualifier while running.
REQ-008 count  output  N  registered current value, bit 0 is MSB ([0:N-1] ordering).
REQ-009 zero  output  1  combinational, high when count == 0.
REQ-010 tc  output  1  registered one-cycle terminal-count pulse.
REQ-011 busy  output  1  registered, high while in RUN state.

Function
REQ-012 States SHALL be IDLE, RUN, DONE; encoding per the shared package.
REQ-013 IDLE: count holds, tc=0, busy=0; load=1 -> count<=load_value, reload_reg<=load_value, next RUN.
REQ-014 RUN, enable=1, count>1: count<=count-1, tc=0.
REQ-015 RUN, enable=1, count==1: count<=0, tc<=1 for exactly that next cycle.
REQ-016 RUN, enable=1, count==0, AUTO_RELOAD=1: count<=reload_reg, stay RUN (period = reload_reg+1 enabled cycles).
REQ-017 RUN, count reaches 0, AUTO_RELOAD=0: next state DONE at the same edge count becomes 0; count holds 0.
REQ-018 RUN, enable=0: count, state hold; tc=0.
REQ-019 DONE: count holds 0, busy=0, tc=0; load=1 -> same action as REQ-013.
REQ-020 load=1 in any state SHALL take priority over enable and restart from load_value (RUN abort permitted).
REQ-021 load with load_value==0: count<=0, tc<=1 same edge; one-shot -> DONE; AUTO_RELOAD -> RUN, next enabled cycle reloads 0, tc pulses every enabled cycle.
REQ-022 Decrement SHALL never wrap below 0; no N-bit underflow to all-ones ever visible on count.
REQ-023 Latency: load sampled at edge k -> count==load_value and busy=1 visible after edge k.
REQ-024 tc SHALL never be high two consecutive cycles except under REQ-021 reload-of-zero.

Reset
REQ-025 clear=0 at a rising edge: count<=0, reload_reg<=0, state<=IDLE, tc<=0, busy<=0.
REQ-026 clear SHALL override load and enable in the same cycle, including mid-RUN.
REQ-027 After clear returns high, first load SHALL behave per REQ-013 with no residual tc.

Structure
REQ-028 Shared package n_bit_counter_pkg SHALL hold the state enum (IDLE, RUN, DONE) and default width constant (8).
REQ-029 No sub-module; single module, one state register, one count register, one reload register, registered tc/busy.

Verification
REQ-030 clear=0 two cycles, load=1 same time -> count=0, busy=0, tc=0, state IDLE.
REQ-031 N=8 one-shot: load 5, enable=1 continuously -> count 5,4,3,2,1,0; tc high only the cycle count first reads 0; busy falls same cycle; count holds 0.
REQ-032 Enable gaps: load 3, enable pattern 1,0,0,1,1 -> count 3,2,2,2,1,0; tc on the 0 cycle only.
REQ-033 AUTO_RELOAD=1: load 2, enable=1 -> count 2,1,0,2,1,0,...; tc every 3rd cycle.
REQ-034 Mid-run reload: load 200, after 10 decrements (count 190) assert load with 7 -> count 7 next cycle, no tc.
REQ-035 Mid-run clear at count 190 with load=1 -> count 0, IDLE, busy=0; load 0 in one-shot -> tc one cycle, DONE.
